// File: rtl/led_arb_pkg.sv
// Shared types and widths for the LED bank arbiter.
package led_arb_pkg;
  localparam int LED_WIDTH = 8;
  localparam int DUR_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, SHOW, RELEASE} state_e;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above pointer, wrapping upward.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       valid
);
  localparam int PW = $clog2(NUM_REQ);

  // Walk from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(pointer) + i) % NUM_REQ]) begin
        onehot = '0;
        onehot[(int'(pointer) + i) % NUM_REQ] = 1'b1;
        index  = PW'((int'(pointer) + i) % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_bank_arbiter.sv
// Shares the 8 active-low user LEDs between NUM_REQ requesters; idle shows a tick counter.
module led_bank_arbiter import led_arb_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int TICK_BITS = 21
) (
  input  logic                              clk_50mhz,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][LED_WIDTH-1:0] pattern,
  input  logic [NUM_REQ-1:0][DUR_WIDTH-1:0] duration,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                done,
  output logic                              busy,
  output logic [LED_WIDTH-1:0]              led_n
);
  localparam int PW = $clog2(NUM_REQ);

  state_e               state;
  logic [TICK_BITS-1:0] presc;
  logic                 tick;
  logic [LED_WIDTH-1:0] idle_cnt;
  logic [LED_WIDTH-1:0] pat_q;
  logic [DUR_WIDTH:0]   ticks_left;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        owner;
  logic [NUM_REQ-1:0]   win_oh;
  logic [PW-1:0]        win_idx;
  logic                 win_vld;

  assign tick = &presc;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .pointer (rr_ptr),
    .onehot  (win_oh),
    .index   (win_idx),
    .valid   (win_vld)
  );

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      idle_cnt   <= '0;
      pat_q      <= '0;
      ticks_left <= '0;
      rr_ptr     <= '0;
      owner      <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      led_n      <= '1;
    end else begin
      presc <= presc + 1'b1;
      done  <= '0;
      led_n <= (state == IDLE) ? ~idle_cnt : ~pat_q;
      case (state)
        IDLE: begin
          if (tick) idle_cnt <= idle_cnt + 1'b1;
          if (win_vld) begin
            state      <= SHOW;
            grant      <= win_oh;
            owner      <= win_idx;
            pat_q      <= pattern[win_idx];
            // A zero duration encodes the full 256-tick window.
            ticks_left <= (duration[win_idx] == '0) ? {1'b1, {DUR_WIDTH{1'b0}}}
                                                    : {1'b0, duration[win_idx]};
            presc      <= '0;
            busy       <= 1'b1;
          end
        end
        SHOW: begin
          if (!req[owner]) begin
            state <= RELEASE;
            grant <= '0;
          end else if (tick) begin
            ticks_left <= ticks_left - 1'b1;
            if (ticks_left == (DUR_WIDTH+1)'(1)) begin
              state <= RELEASE;
              grant <= '0;
              done  <= grant;
            end
          end
        end
        RELEASE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scenario tasks plus a cycle-count reference model scoring every cycle.
module tb_led_bank_arbiter;
  localparam int N   = 4;
  localparam int TB  = 2;
  localparam int CPT = 1 << TB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0][7:0] pattern  = '0;
  logic [N-1:0][7:0] duration = '0;
  logic [N-1:0]     grant, done;
  logic             busy;
  logic [7:0]       led_n;

  int checks = 0;
  int passed = 0;
  bit mon_en = 1'b0;

  led_bank_arbiter #(.NUM_REQ(N), .TICK_BITS(TB)) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .req       (req),
    .pattern   (pattern),
    .duration  (duration),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .led_n     (led_n)
  );

  always #5 clk = ~clk;

  // Reference model: owner's window counted directly in clock cycles.
  int           m_st = 0, m_pre = 0, m_ptr = 0, m_own = 0, m_left = 0, m_w;
  logic [7:0]   m_idle = '0, m_pat = '0, m_led = 8'hff;
  logic [N-1:0] m_grant = '0, m_done = '0;
  logic         m_busy = 1'b0;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always_comb m_w = pick(req, m_ptr);

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_pre <= 0; m_ptr <= 0; m_own <= 0; m_left <= 0;
      m_idle <= '0; m_pat <= '0; m_led <= 8'hff;
      m_grant <= '0; m_done <= '0; m_busy <= 1'b0;
    end else begin
      m_led  <= (m_st == 0) ? ~m_idle : ~m_pat;
      m_pre  <= (m_pre + 1) % CPT;
      m_done <= '0;
      if (m_st == 0) begin
        if (m_pre == CPT - 1) m_idle <= m_idle + 8'd1;
        if (m_w >= 0) begin
          m_st    <= 1;
          m_own   <= m_w;
          m_pat   <= pattern[m_w];
          m_left  <= ((duration[m_w] == 8'd0) ? 256 : int'(duration[m_w])) * CPT;
          m_pre   <= 0;
          m_grant <= N'(1) << m_w;
          m_busy  <= 1'b1;
        end
      end else if (m_st == 1) begin
        if (!req[m_own]) begin
          m_st <= 2; m_grant <= '0;
        end else if (m_left == 1) begin
          m_st <= 2; m_grant <= '0; m_done <= N'(1) << m_own;
        end else m_left <= m_left - 1;
      end else begin
        m_st <= 0; m_busy <= 1'b0; m_ptr <= (m_own + 1) % N;
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    checks++;
    if ({grant, done, busy, led_n} !== {m_grant, m_done, m_busy, m_led})
      $display("FAIL model t=%0t got g=%b d=%b b=%b led=%h want g=%b d=%b b=%b led=%h",
               $time, grant, done, busy, led_n, m_grant, m_done, m_busy, m_led);
    else passed++;
  end

  task automatic test_reset();
    int changes = 0, bad = 0;
    logic [7:0] prev;
    rst = 1'b1; req = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checks++; if (grant !== '0) $display("FAIL reset_grant got %b want 0", grant); else passed++;
    checks++; if (done !== '0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (led_n !== 8'hff) $display("FAIL reset_led got %h want ff", led_n); else passed++;
    rst = 1'b0;
    prev = led_n;
    repeat (40) begin
      @(negedge clk);
      if (led_n !== prev) changes++;
      prev = led_n;
      if (grant !== '0 || done !== '0) bad++;
    end
    checks++; if (changes != 9) $display("FAIL idle_steps got %0d want 9", changes); else passed++;
    checks++; if (led_n !== 8'hf6) $display("FAIL idle_led got %h want f6", led_n); else passed++;
    checks++; if (bad != 0) $display("FAIL idle_quiet got %0d want 0", bad); else passed++;
  endtask

  task automatic test_single();
    int k = 0, len = 0;
    pattern[1] = 8'ha5; duration[1] = 8'd3; req = 4'b0010;
    while (grant === '0 && k < 10) begin @(negedge clk); k++; end
    checks++; if (grant !== 4'b0010) $display("FAIL single_grant got %b want 0010", grant); else passed++;
    while (grant === 4'b0010 && len < 60) begin
      len++;
      @(negedge clk);
      if (len == 1) begin
        checks++; if (led_n !== 8'h5a) $display("FAIL single_led got %h want 5a", led_n); else passed++;
      end
    end
    checks++; if (len != 12) $display("FAIL single_len got %0d want 12", len); else passed++;
    checks++; if (done !== 4'b0010) $display("FAIL single_done got %b want 0010", done); else passed++;
    req = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_fair();
    logic [N-1:0] prev = '0, e;
    logic [N-1:0] gs[$], ds[$];
    int lens[$], gaps[$];
    int run = 0, gap = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) begin duration[i] = 8'd1; pattern[i] = 8'($urandom); end
    req = 4'b1111;
    repeat (30) begin
      @(negedge clk);
      if (done !== '0) ds.push_back(done);
      if (grant !== '0) begin
        if (prev === '0) begin gs.push_back(grant); if (gs.size() > 1) gaps.push_back(gap); end
        run++;
      end else begin
        if (prev !== '0) begin lens.push_back(run); run = 0; gap = 1; end
        else gap++;
      end
      prev = grant;
    end
    req = '0;
    checks++;
    if (gs.size() != 5 || lens.size() != 5 || ds.size() != 5 || gaps.size() != 4)
      $display("FAIL fair_counts got g=%0d l=%0d d=%0d gap=%0d want 5 5 5 4",
               gs.size(), lens.size(), ds.size(), gaps.size());
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        e = 4'b0001 << (i % N);
        checks++; if (gs[i] !== e) $display("FAIL fair_order[%0d] got %b want %b", i, gs[i], e); else passed++;
        checks++; if (ds[i] !== e) $display("FAIL fair_done[%0d] got %b want %b", i, ds[i], e); else passed++;
        checks++; if (lens[i] != CPT) $display("FAIL fair_len[%0d] got %0d want %0d", i, lens[i], CPT); else passed++;
        if (i < 4) begin
          checks++; if (gaps[i] != 2) $display("FAIL fair_gap[%0d] got %0d want 2", i, gaps[i]); else passed++;
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int k = 0, dn = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    duration[2] = 8'd5; pattern[2] = 8'h3c; req = 4'b0100;
    while (grant === '0 && k < 10) begin @(negedge clk); k++; end
    checks++; if (grant !== 4'b0100) $display("FAIL abort_grant got %b want 0100", grant); else passed++;
    repeat (5) @(negedge clk);
    req = '0;
    @(negedge clk);
    checks++; if (grant !== '0) $display("FAIL abort_drop got %b want 0", grant); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL abort_busy got %b want 1", busy); else passed++;
    if (done !== '0) dn++;
    repeat (4) begin @(negedge clk); if (done !== '0) dn++; end
    checks++; if (dn != 0) $display("FAIL abort_nodone got %0d want 0", dn); else passed++;
    for (int i = 0; i < N; i++) duration[i] = 8'd1;
    req = 4'b1111; k = 0;
    while (grant === '0 && k < 10) begin @(negedge clk); k++; end
    checks++; if (grant !== 4'b1000) $display("FAIL abort_next got %b want 1000", grant); else passed++;
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_dur0();
    int k = 0, len = 0;
    duration[0] = 8'd0; req = 4'b0001;
    while (grant === '0 && k < 10) begin @(negedge clk); k++; end
    while (grant === 4'b0001 && len < 1100) begin len++; @(negedge clk); end
    checks++; if (len != 256 * CPT) $display("FAIL dur0_len got %0d want %0d", len, 256 * CPT); else passed++;
    checks++; if (done !== 4'b0001) $display("FAIL dur0_done got %b want 0001", done); else passed++;
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k = 0, dn = 0;
    duration[0] = 8'd10; req = 4'b0001;
    while (grant === '0 && k < 10) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (grant !== '0) $display("FAIL rstmid_grant got %b want 0", grant); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    checks++; if (led_n !== 8'hff) $display("FAIL rstmid_led got %h want ff", led_n); else passed++;
    if (done !== '0) dn++;
    rst = 1'b0; req = 4'b1111; k = 0;
    while (grant === '0 && k < 10) begin @(negedge clk); k++; if (done !== '0) dn++; end
    checks++; if (grant !== 4'b0001) $display("FAIL rstmid_next got %b want 0001", grant); else passed++;
    checks++; if (dn != 0) $display("FAIL rstmid_nodone got %0d want 0", dn); else passed++;
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        pattern[i]  = 8'($urandom);
        duration[i] = 8'($urandom_range(1, 3));
      end
    end
    req = '0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fair();
    test_abort();
    test_dur0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the board's 8 active-low user LEDs between up to NUM_REQ on-chip requesters, e.g. a status reporter, a debug pattern source and a heartbeat.
- Each request carries an 8-bit pattern and a display duration in prescaler ticks. The winning requester owns the LED bank for exactly that duration.
- With no requester active, the bank shows a free-running binary count that advances once per tick.
- Sits between internal status logic and the top-level led_n pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_BITS, 21, prescaler width; one tick = 2^TICK_BITS clk_50mhz cycles (about 42 ms at 50 MHz).

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  level request, one bit per requester
- pattern  in  NUM_REQ x 8  LED pattern per requester, active-high
- duration  in  NUM_REQ x 8  display time in ticks; 0 means 256
- grant  out  NUM_REQ  one-hot, high while the requester owns the bank
- done  out  NUM_REQ  one-hot, one-cycle pulse on normal completion
- busy  out  1  high in SHOW and RELEASE
- led_n  out  8  active-low LED drive, registered

Behaviour:
- Reset values: state IDLE, grant 0, done 0, busy 0, led_n 8'hff, idle counter 0, prescaler 0, round-robin pointer 0.
- Prescaler:
  - Free-running TICK_BITS counter.
  - tick = prescaler is all ones.
  - Cleared to 0 on the IDLE->SHOW transition.
- State IDLE:
  - Display = idle counter; idle counter increments (mod 256) on each tick.
  - If req != 0: pick the first set bit at or after the rr pointer, rotating upward with wrap.
  - At that edge: grant <= onehot(winner), latch pattern and duration of the winner, ticks_left <= duration (0 -> 256), prescaler <= 0, state <= SHOW.
- State SHOW:
  - Display = latched pattern; grant held; other requesters ignored.
  - On a tick, ticks_left decrements. On a tick with ticks_left == 1: state <= RELEASE, grant <= 0.
  - SHOW therefore lasts exactly d * 2^TICK_BITS cycles.
  - Abort: if req[owner] drops during SHOW, then next edge state <= RELEASE, grant <= 0, and no done pulse.
  - Pattern/duration input changes during SHOW have no effect.
- State RELEASE (1 cycle):
  - done[owner] pulses only if not aborted.
  - rr pointer <= (owner + 1) mod NUM_REQ; state <= IDLE.
  - Display = latched pattern.
  - Idle counter holds its value from entry to SHOW through RELEASE.
- Back-to-back: a pending request is granted on the edge leaving IDLE, so grant is low for exactly 2 cycles between owners.
- Output: led_n <= ~display every cycle, so LEDs lag the state by 1 cycle.
- Fairness: with all req held high, grants rotate 0,1,2,...,NUM_REQ-1,0.
- A req that rises and falls while another requester owns the bank is never granted; there is no request latching.
- Reset mid-SHOW: grant drops and led_n = 8'hff on the following cycle; no done pulse.

Decomposition:
- Package led_arb_pkg:
  - state enum {IDLE, SHOW, RELEASE}
  - LED_WIDTH = 8
  - DUR_WIDTH = 8
- Sub-module rr_pick: combinational rotating-priority one-hot picker.
  - Inputs: req, pointer.
  - Outputs: onehot, index, valid.
  - Parameterised by NUM_REQ; reusable elsewhere.
- Prescaler and FSM remain in led_bank_arbiter.

Test Plan (TICK_BITS=2, so 4 cycles per tick):
- Reset, no req, run 40 cycles -> led_n steps 8'hff, 8'hfe, 8'hfd, ... once per 4 cycles; grant and done stay 0.
- req=4'b0010, pattern[1]=8'hA5, duration[1]=3 -> grant=4'b0010 for exactly 12 cycles; led_n=8'h5A starting 1 cycle after grant; then done=4'b0010 for 1 cycle; idle count resumes from its held value.
- req=4'b1111 held, all durations 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each high 4 cycles with a 2-cycle gap; done pulses follow the same order.
- Owner 2 granted with duration 5, req[2] dropped after 6 cycles -> grant falls next edge, no done pulse, rr pointer = 3.
- duration=0 -> grant lasts 256*4 = 1024 cycles.
- rst pulsed mid-SHOW -> grant=0, busy=0 and led_n=8'hff the next cycle; no done pulse; next grant starts from requester 0.
